// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared encodings and address map for mem_responder
package mem_resp_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  localparam logic [8:0] ADDR_SW  = 9'h140;
  localparam logic [8:0] ADDR_LED = 9'h100;
  localparam int         RAM_AW   = 8;

  // Encoding 2'b11 is deliberately folded into NONE.
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// rtl/mem_resp_ram.sv - single-port synchronous RAM with registered read
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [15:0]       din,
  output logic [15:0]       dout
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - CPU bus responder for RAM, switch and LED registers
// Optional wait states in ACCESS are enabled by defining MEM_RESP_WAIT_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int RAM_DEPTH   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        mem_ready,
  input  logic [7:0]  sw_in,
  output logic [7:0]  led_out,
  output logic        addr_err
);

  state_e            state, state_nxt;
  logic [1:0]        cmd_q;
  logic [8:0]        addr_q;
  logic [15:0]       wdata_q;
  logic [7:0]        sw_meta, sw_sync;
  logic [15:0]       ram_dout;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic              last_access;
  logic              commit;
  logic              start;
  logic              is_ram;

  assign start  = (state == ST_IDLE) && is_req(mem_cmd);
  assign is_ram = (addr_q[8] == 1'b0);

`ifdef MEM_RESP_WAIT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= 8'(WAIT_CYCLES);
    end else if ((state == ST_ACCESS) && (wait_cnt != 8'd0)) begin
      wait_cnt <= wait_cnt - 8'd1;
    end
  end

  assign last_access = (wait_cnt == 8'd0);
`else
  logic [31:0] wait_cycles_unused;
  assign wait_cycles_unused = WAIT_CYCLES;
  assign last_access        = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_ready = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_req(mem_cmd)) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (last_access) begin
          commit    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        mem_ready = 1'b1;
        if (!is_req(mem_cmd)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // RAM is addressed straight from the bus in IDLE so its read latency
  // overlaps the request edge; afterwards the latched address holds it.
  assign ram_addr = (state == ST_IDLE) ? mem_addr[RAM_AW-1:0] : addr_q[RAM_AW-1:0];
  assign ram_we   = commit && (cmd_q == CMD_WRITE) && is_ram && !reset;

  mem_resp_ram #(
    .DEPTH(RAM_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q     <= CMD_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
      led_out   <= '0;
      addr_err  <= 1'b0;
    end else begin
      if (start) begin
        cmd_q   <= mem_cmd;
        addr_q  <= mem_addr;
        wdata_q <= write_data;
      end
      if (commit) begin
        if (cmd_q == CMD_READ) begin
          if (is_ram) begin
            read_data <= ram_dout;
          end else if (addr_q == ADDR_SW) begin
            read_data <= {8'h00, sw_sync};
          end else begin
            read_data <= '0;
            addr_err  <= 1'b1;
          end
        end else begin
          if (addr_q == ADDR_LED) begin
            led_out <= wdata_q[7:0];
          end else if (!is_ram) begin
            addr_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized bench with transaction-level model for mem_responder
module tb_mem_responder;

`ifdef MEM_RESP_WAIT_EN
  localparam int WC      = 3;
  localparam int LAT_EXP = 4;
`else
  localparam int WC      = 2;
  localparam int LAT_EXP = 1;
`endif

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;
  logic [7:0]  sw_in;
  logic [7:0]  led_out;
  logic        addr_err;

  mem_responder #(
    .WAIT_CYCLES (WC),
    .RAM_DEPTH   (256)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_ready  (mem_ready),
    .sw_in      (sw_in),
    .led_out    (led_out),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        chk_en   = 1'b0;
  logic        exp_ready;
  logic [15:0] exp_rdata;
  logic [7:0]  exp_led;
  logic        exp_err;
  logic [15:0] mram [256];
  logic [15:0] got_rdata;
  int          lat;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_ready", {15'd0, mem_ready}, {15'd0, exp_ready});
      check("read_data", read_data, exp_rdata);
      check("led_out", {8'd0, led_out}, {8'd0, exp_led});
      check("addr_err", {15'd0, addr_err}, {15'd0, exp_err});
    end
  end

  task automatic model_reset();
    exp_ready = 1'b0;
    exp_rdata = 16'h0000;
    exp_led   = 8'h00;
    exp_err   = 1'b0;
  endtask

  task automatic model_commit(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
    if (cmd == C_READ) begin
      if (addr < 9'h100)       exp_rdata = mram[addr[7:0]];
      else if (addr == 9'h140) exp_rdata = {8'h00, sw_in};
      else begin
        exp_rdata = 16'h0000;
        exp_err   = 1'b1;
      end
    end else begin
      if (addr < 9'h100)       mram[addr[7:0]] = data;
      else if (addr == 9'h100) exp_led = data[7:0];
      else                     exp_err = 1'b1;
    end
    exp_ready = 1'b1;
  endtask

  // Called at 1 time unit after an active edge with the DUT in IDLE.
  task automatic txn(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data, input int hold);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = data;
    @(posedge clk); #1;
    lat = 0;
    for (int i = 0; i < LAT_EXP; i++) begin
      mem_cmd    = 2'($urandom);
      mem_addr   = 9'($urandom);
      write_data = 16'($urandom);
      @(posedge clk); #1;
      if (mem_ready && lat == 0) lat = i + 1;
    end
    model_commit(cmd, addr, data);
    got_rdata = read_data;
    check("latency", 16'(lat), 16'(LAT_EXP));
    for (int h = 0; h < hold; h++) begin
      mem_cmd    = 2'($urandom_range(1, 2));
      mem_addr   = 9'($urandom);
      write_data = 16'($urandom);
      @(posedge clk); #1;
    end
    mem_cmd = ($urandom_range(0, 1) == 0) ? C_NONE : 2'b11;
    @(posedge clk); #1;
    exp_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_cmd = ($urandom_range(0, 1) == 0) ? C_NONE : 2'b11;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [8:0] a;
    int         r;
    reset      = 1'b1;
    mem_cmd    = C_NONE;
    mem_addr   = '0;
    write_data = '0;
    sw_in      = 8'h00;
    model_reset();
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    idle(10);
    check("rst_ready", {15'd0, mem_ready}, 16'd0);
    check("rst_rdata", read_data, 16'h0000);
    check("rst_led", {8'd0, led_out}, 16'd0);
    check("rst_err", {15'd0, addr_err}, 16'd0);

    for (int i = 0; i < 256; i++) txn(C_WRITE, 9'(i), 16'($urandom), 0);

    txn(C_WRITE, 9'h00B, 16'hABCD, 0);
    txn(C_READ, 9'h00B, 16'h0000, 0);
    check("rd_00B", got_rdata, 16'hABCD);

    txn(C_WRITE, 9'h100, 16'h12A5, 0);
    check("led_A5", {8'd0, led_out}, 16'h00A5);
    sw_in = 8'h3C;
    idle(3);
    txn(C_READ, 9'h140, 16'h0000, 0);
    check("rd_sw", got_rdata, 16'h003C);

    txn(C_READ, 9'h180, 16'h0000, 0);
    check("rd_unmapped", got_rdata, 16'h0000);
    check("err_set", {15'd0, addr_err}, 16'd1);
    txn(C_WRITE, 9'h1FF, 16'hFFFF, 1);
    check("led_kept", {8'd0, led_out}, 16'h00A5);
    check("err_sticky", {15'd0, addr_err}, 16'd1);

    txn(C_READ, 9'h00B, 16'h0000, 5);
    check("rd_hold", got_rdata, 16'hABCD);

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 15) == 0) begin
        sw_in = 8'($urandom);
        idle(3);
      end
      r = $urandom_range(0, 9);
      if (r <= 5)      a = {1'b0, 8'($urandom)};
      else if (r == 6) a = 9'h100;
      else if (r == 7) a = 9'h140;
      else             a = 9'($urandom);
      txn(($urandom_range(0, 1) == 0) ? C_READ : C_WRITE, a, 16'($urandom), $urandom_range(0, 3));
      idle($urandom_range(0, 2));
    end

    txn(C_WRITE, 9'h020, 16'h1111, 0);
    mem_cmd    = C_WRITE;
    mem_addr   = 9'h020;
    write_data = 16'h5555;
    @(posedge clk); #1;
    for (int i = 0; i < LAT_EXP - 1; i++) begin
      @(posedge clk); #1;
    end
    reset   = 1'b1;
    mem_cmd = C_NONE;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("err_cleared", {15'd0, addr_err}, 16'd0);
    check("led_cleared", {8'd0, led_out}, 16'd0);
    idle(2);
    txn(C_READ, 9'h020, 16'h0000, 0);
    check("rd_after_rst", got_rdata, 16'h1111);
    idle(3);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
